// File: rtl/player_ctl.sv
// Per-frame player motion controller: saturating horizontal walk plus a
// jump/gravity FSM, with the position bus updated only at the vblank rising edge.
module player_ctl #(
  parameter int unsigned X_START = 320,
  parameter int unsigned X_MIN   = 0,
  parameter int unsigned X_MAX   = 704,
  parameter int unsigned Y_FLOOR = 640,
  parameter int unsigned STEP    = 4,
  parameter int unsigned JUMP_V  = 16,
  parameter int unsigned GRAVITY = 1,
  parameter int unsigned V_MAX   = 16
) (
  input  logic        i_pclk,
  input  logic        i_rst_n,
  input  logic        i_vblnk,
  input  logic        i_left,
  input  logic        i_right,
  input  logic        i_jump,
  input  logic        i_restart,
  output logic [19:0] o_data,
  output logic        o_airborne,
  output logic        o_frame_tick
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  localparam logic [10:0] X_START_W = 11'(X_START);
  localparam logic [10:0] X_MIN_W   = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
  localparam logic [10:0] Y_FLOOR_W = 11'(Y_FLOOR);
  localparam logic [10:0] STEP_W    = 11'(STEP);
  localparam logic [5:0]  JUMP_W    = 6'(JUMP_V);
  localparam logic [5:0]  GRAV_W    = 6'(GRAVITY);
  localparam logic [6:0]  VMAX_W    = 7'(V_MAX);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [5:0]  vy_q, vy_d;
  logic        armed_q, armed_d;
  logic        vblnk_q;
  logic        airborne_q;
  logic        frame_tick_q;
  logic        tick;

  // 11-bit arithmetic keeps edge cases from wrapping at 0 or 1023.
  logic [10:0] x_ext, x_dec, x_inc, y_ext, y_up, y_down;
  logic [6:0]  vy_inc;
  logic [5:0]  vy_dec, vy_fall;
  logic        y_sat;

  assign tick    = i_vblnk & ~vblnk_q;
  assign x_ext   = {1'b0, x_q};
  assign x_dec   = x_ext - STEP_W;
  assign x_inc   = x_ext + STEP_W;
  assign y_ext   = {1'b0, y_q};
  assign y_up    = y_ext - {5'd0, vy_q};
  assign y_sat   = y_up[10];
  assign vy_dec  = vy_q - GRAV_W;
  assign vy_inc  = {1'b0, vy_q} + {1'b0, GRAV_W};
  assign vy_fall = (vy_inc > VMAX_W) ? VMAX_W[5:0] : vy_inc[5:0];
  assign y_down  = y_ext + {5'd0, vy_fall};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vy_d    = vy_q;
    armed_d = armed_q;
    if (tick) begin
      if (i_left && !i_right) begin
        x_d = (x_ext < X_MIN_W + STEP_W) ? X_MIN_W[9:0] : x_dec[9:0];
      end else if (i_right && !i_left) begin
        x_d = (x_inc > X_MAX_W) ? X_MAX_W[9:0] : x_inc[9:0];
      end
      case (state_q)
        ST_GROUND: begin
          if (i_jump && armed_q) begin
            state_d = ST_RISE;
            vy_d    = JUMP_W;
            armed_d = 1'b0;
          end else begin
            y_d  = Y_FLOOR_W[9:0];
            vy_d = 6'd0;
          end
        end
        ST_RISE: begin
          y_d  = y_sat ? 10'd0 : y_up[9:0];
          vy_d = vy_dec;
          if (vy_dec == 6'd0 || y_sat) begin
            state_d = ST_FALL;
            vy_d    = 6'd0;
          end
        end
        ST_FALL: begin
          vy_d = vy_fall;
          y_d  = y_down[9:0];
          if (y_down >= Y_FLOOR_W) begin
            y_d     = Y_FLOOR_W[9:0];
            vy_d    = 6'd0;
            state_d = ST_GROUND;
          end
        end
        default: begin
          state_d = ST_GROUND;
          y_d     = Y_FLOOR_W[9:0];
          vy_d    = 6'd0;
        end
      endcase
      // Release must be seen on a tick before the next launch is allowed.
      if (!i_jump) armed_d = 1'b1;
    end
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vblnk_q      <= 1'b0;
      state_q      <= ST_GROUND;
      x_q          <= X_START_W[9:0];
      y_q          <= Y_FLOOR_W[9:0];
      vy_q         <= 6'd0;
      armed_q      <= 1'b1;
      airborne_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      // vblnk_q keeps tracking through restart so a long vblank yields one tick.
      vblnk_q <= i_vblnk;
      if (i_restart) begin
        state_q      <= ST_GROUND;
        x_q          <= X_START_W[9:0];
        y_q          <= Y_FLOOR_W[9:0];
        vy_q         <= 6'd0;
        armed_q      <= 1'b1;
        airborne_q   <= 1'b0;
        frame_tick_q <= 1'b0;
      end else begin
        state_q      <= state_d;
        x_q          <= x_d;
        y_q          <= y_d;
        vy_q         <= vy_d;
        armed_q      <= armed_d;
        airborne_q   <= (state_d != ST_GROUND);
        frame_tick_q <= tick;
      end
    end
  end

  assign o_data       = {y_q, x_q};
  assign o_airborne   = airborne_q;
  assign o_frame_tick = frame_tick_q;

endmodule

// File: tb/tb_player_ctl.sv
// Bench for player_ctl: frame-level motion model, per-cycle comparison,
// per-tick position scoreboard and hand-computed literal checkpoints.
module tb_player_ctl;

  logic        clk;
  logic        rst_n;
  logic        vblnk, left, right, jump, restart;
  logic [19:0] o_data;
  logic        o_airborne, o_frame_tick;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 0;
  int tick_cnt = 0;
  logic [19:0] exp_q[$];

  player_ctl dut (
    .i_pclk      (clk),
    .i_rst_n     (rst_n),
    .i_vblnk     (vblnk),
    .i_left      (left),
    .i_right     (right),
    .i_jump      (jump),
    .i_restart   (restart),
    .o_data      (o_data),
    .o_airborne  (o_airborne),
    .o_frame_tick(o_frame_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: one frame step from the motion rules
  typedef struct {
    int x;
    int y;
    int vy;
    bit air;
    bit up;
    bit armed;
  } mdl_t;

  localparam mdl_t M_RESET = '{x: 320, y: 640, vy: 0, air: 0, up: 0, armed: 1};

  mdl_t m;
  bit   m_vb;
  bit   m_tick;

  function automatic mdl_t frame_step(input mdl_t s, input bit l, input bit r, input bit j);
    mdl_t n = s;
    if (l && !r) n.x = (s.x - 4 < 0) ? 0 : s.x - 4;
    if (r && !l) n.x = (s.x + 4 > 704) ? 704 : s.x + 4;
    if (!s.air) begin
      if (j && s.armed) begin
        n.air = 1; n.up = 1; n.vy = 16; n.armed = 0;
      end else begin
        n.y = 640; n.vy = 0;
      end
    end else if (s.up) begin
      bit sat;
      sat  = (s.y - s.vy < 0);
      n.y  = sat ? 0 : s.y - s.vy;
      n.vy = s.vy - 1;
      if (n.vy == 0 || sat) begin n.up = 0; n.vy = 0; end
    end else begin
      n.vy = (s.vy + 1 > 16) ? 16 : s.vy + 1;
      n.y  = s.y + n.vy;
      if (n.y >= 640) begin n.y = 640; n.vy = 0; n.air = 0; end
    end
    if (!j) n.armed = 1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m      <= M_RESET;
      m_vb   <= 1'b0;
      m_tick <= 1'b0;
    end else begin
      m_vb <= vblnk;
      if (restart) begin
        m      <= M_RESET;
        m_tick <= 1'b0;
      end else if (vblnk && !m_vb) begin
        mdl_t nx;
        nx = frame_step(m, left, right, jump);
        m      <= nx;
        m_tick <= 1'b1;
        exp_q.push_back({nx.y[9:0], nx.x[9:0]});
      end else begin
        m_tick <= 1'b0;
      end
    end
  end

  // compare process and scoreboard, on the inactive edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("data", o_data, {m.y[9:0], m.x[9:0]});
      chk("airborne", o_airborne, m.air);
      chk("frame_tick", o_frame_tick, m_tick);
      if (o_frame_tick) begin
        tick_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_pos: got %0d with no expected entry", o_data);
        end else begin
          chk("sb_pos", o_data, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic frame(input bit l, input bit r, input bit j);
    @(posedge clk); #1;
    left = l; right = r; jump = j; vblnk = 1'b0;
    @(posedge clk); #1 vblnk = 1'b1;
    repeat (3) @(posedge clk);
    #1 vblnk = 1'b0;
  endtask

  task automatic frames(input int n, input bit l, input bit r, input bit j);
    for (int i = 0; i < n; i++) frame(l, r, j);
  endtask

  task automatic restart_pulse();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
  endtask

  task automatic chk_pos(input string name, input int x, input int y, input bit air);
    logic [9:0] xv, yv;
    xv = 10'(x);
    yv = 10'(y);
    chk({name, "_data"}, o_data, {yv, xv});
    chk({name, "_air"}, o_airborne, air);
  endtask

  initial begin
    int air_cnt;
    rst_n = 1'b0; vblnk = 1'b0; left = 1'b0; right = 1'b0; jump = 1'b0; restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_pos("reset", 320, 640, 1'b0);
    chk("reset_tick", o_frame_tick, 1'b0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // walk right, saturate, both buttons
    frames(10, 0, 1, 0);
    chk_pos("walk10", 360, 640, 1'b0);
    chk("walk10_ticks", tick_cnt, 10);
    frames(100, 0, 1, 0);
    chk_pos("walk_sat", 704, 640, 1'b0);
    frames(3, 1, 1, 0);
    chk_pos("walk_both", 704, 640, 1'b0);

    // left saturation
    restart_pulse();
    chk_pos("restart_pulse", 320, 640, 1'b0);
    frames(80, 1, 0, 0);
    chk_pos("left80", 0, 640, 1'b0);
    frames(5, 1, 0, 0);
    chk_pos("left85", 0, 640, 1'b0);

    // jump arc
    restart_pulse();
    frame(0, 0, 1);
    chk_pos("arc_t1", 320, 640, 1'b1);
    frames(16, 0, 0, 0);
    chk_pos("arc_t17", 320, 504, 1'b1);
    frames(15, 0, 0, 0);
    chk_pos("arc_t32", 320, 624, 1'b1);
    frame(0, 0, 0);
    chk_pos("arc_t33", 320, 640, 1'b0);

    // held jump: one arc only, then re-arm
    air_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      frame(0, 0, 1);
      if (o_airborne) air_cnt++;
    end
    chk("held_air_frames", air_cnt, 32);
    chk_pos("held_end", 320, 640, 1'b0);
    frame(0, 0, 0);
    frame(0, 0, 1);
    chk_pos("rearm", 320, 640, 1'b1);

    // restart coincident with a tick, mid-arc, right held
    frames(5, 0, 1, 0);
    @(posedge clk); #1;
    left = 1'b0; right = 1'b1; jump = 1'b0; vblnk = 1'b0;
    @(posedge clk); #1 vblnk = 1'b1; restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    chk_pos("restart_tick", 320, 640, 1'b0);
    chk("restart_tick_pulse", o_frame_tick, 1'b0);
    repeat (3) @(posedge clk);
    #1 vblnk = 1'b0;
    chk_pos("restart_no_retick", 320, 640, 1'b0);

    // asynchronous reset mid-jump
    frame(0, 0, 0);
    frame(0, 0, 1);
    frames(6, 0, 0, 0);
    chk_pos("pre_reset", 320, 559, 1'b1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk_pos("async_reset", 320, 640, 1'b0);
    chk("async_reset_tick", o_frame_tick, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    frame(1, 0, 0);
    chk_pos("post_reset", 316, 640, 1'b0);

    repeat (2) @(posedge clk);
    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
